// File: rtl/uart_cmd_executor_pkg.sv
// Shared constants for the UART command executor: state encoding, memory select,
// read/write flag encoding and the default write acknowledge byte.
package uart_cmd_executor_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CNT_W   = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WRITE = 3'd1;
  localparam logic [2:0] ST_READ  = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_SEND  = 3'd4;

  localparam logic MEM_INSTR = 1'b0;
  localparam logic MEM_DATA  = 1'b1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/tx_byte_serializer.sv
// Shifts a loaded word out MSB byte first over a valid/ready byte handshake;
// tx_valid and tx_byte are register outputs and never depend on tx_ready.
module tx_byte_serializer
  import uart_cmd_executor_pkg::*;
#(
  parameter int unsigned BYTE_COUNT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [8*BYTE_COUNT-1:0] load_word,
  input  logic [CNT_W-1:0]        load_count,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    done_c
);

  localparam int unsigned WORD_W = 8 * BYTE_COUNT;

  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      shreg    <= load_word;
      cnt      <= load_count;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shreg    <= {shreg[WORD_W-9:0], 8'h00};
      cnt      <= cnt - CNT_W'(1);
      tx_valid <= (cnt != CNT_W'(1));
    end
  end

  assign tx_byte = shreg[WORD_W-1 -: 8];
  // Final byte of the burst is being accepted this cycle
  assign done_c  = tx_valid && tx_ready && (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_cmd_executor.sv
// Executes one received UART command against the instruction/data memory port and
// returns an ack byte (write) or the read word (MSB first) through the byte transmitter.
module uart_cmd_executor
  import uart_cmd_executor_pkg::*;
#(
  parameter int unsigned BYTE_COUNT = 4,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  ACK_BYTE   = ACK_BYTE_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_done,
  input  logic [8*BYTE_COUNT-1:0] rx_data,
  input  logic [ADDR_WIDTH-1:0]   rx_addr,
  input  logic                    rx_mem_type,
  input  logic                    rx_rw_flag,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic                    mem_sel,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [8*BYTE_COUNT-1:0] mem_wdata,
  input  logic [8*BYTE_COUNT-1:0] mem_rdata,
  output logic [7:0]              tx_byte,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    busy,
  output logic                    err_overrun
);

  localparam int unsigned WORD_W = 8 * BYTE_COUNT;

  logic [STATE_W-1:0]    state, state_d;
  logic                  rw_q, rw_d;
  logic [CNT_W-1:0]      lat_cnt, lat_d;
  logic                  issued, issued_d;
  logic                  mem_req_d, mem_we_d, mem_sel_d, busy_d, err_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [WORD_W-1:0]     mem_wdata_d;
  logic                  ser_load_c;
  logic [WORD_W-1:0]     ser_word_c;
  logic [CNT_W-1:0]      ser_count_c;
  logic                  ser_done_c;

  // Next-state and next-output logic; issued marks that a state's one-shot action has fired
  always_comb begin
    state_d     = state;
    rw_d        = rw_q;
    lat_d       = lat_cnt;
    issued_d    = issued;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    err_d       = err_overrun | (rx_done & (state != ST_IDLE));
    ser_load_c  = 1'b0;
    ser_word_c  = '0;
    ser_count_c = '0;
    case (state)
      ST_IDLE: begin
        if (rx_done) begin
          mem_addr_d  = rx_addr;
          mem_sel_d   = rx_mem_type;
          mem_wdata_d = rx_data;
          rw_d        = rx_rw_flag;
          issued_d    = 1'b0;
          state_d     = (rx_rw_flag == RW_WRITE) ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        mem_req_d = 1'b1;
        mem_we_d  = (rw_q == RW_WRITE);
        issued_d  = 1'b0;
        state_d   = ST_ACK;
      end
      ST_READ: begin
        if (!issued) begin
          mem_req_d = 1'b1;
          mem_we_d  = (rw_q == RW_WRITE);
          issued_d  = 1'b1;
          lat_d     = CNT_W'(RD_LATENCY);
        end else if (lat_cnt == '0) begin
          ser_load_c  = 1'b1;
          ser_word_c  = mem_rdata;
          ser_count_c = CNT_W'(BYTE_COUNT);
          state_d     = ST_SEND;
        end else begin
          lat_d = lat_cnt - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (!issued) begin
          ser_load_c  = 1'b1;
          ser_word_c  = {ACK_BYTE, {(WORD_W-8){1'b0}}};
          ser_count_c = CNT_W'(1);
          issued_d    = 1'b1;
        end else if (ser_done_c) begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (ser_done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      rw_q        <= 1'b0;
      lat_cnt     <= '0;
      issued      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_sel     <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_d;
      rw_q        <= rw_d;
      lat_cnt     <= lat_d;
      issued      <= issued_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      mem_sel     <= mem_sel_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      busy        <= busy_d;
      err_overrun <= err_d;
    end
  end

  tx_byte_serializer #(
    .BYTE_COUNT(BYTE_COUNT)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load_c),
    .load_word (ser_word_c),
    .load_count(ser_count_c),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done_c    (ser_done_c)
  );

endmodule

// File: tb/tb_uart_cmd_executor.sv
// Directed bench for uart_cmd_executor: cycle vector table for write/read, then
// backpressure, overrun, mid-response reset and a RD_LATENCY=3 instance.
module tb_uart_cmd_executor;
  import uart_cmd_executor_pkg::*;

  localparam logic [31:0] G = 32'hCAFEF00D;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_done;
  logic [31:0] rx_data;
  logic [8:0]  rx_addr;
  logic        rx_mem_type;
  logic        rx_rw_flag;
  logic        tx_ready;
  logic [31:0] mem_rdata;

  logic        mem_req, mem_we, mem_sel, tx_valid, busy, err_overrun;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [7:0]  tx_byte;

  logic        mem_req3, mem_we3, mem_sel3, tx_valid3, busy3, err_overrun3;
  logic [8:0]  mem_addr3;
  logic [31:0] mem_wdata3, mem_rdata3;
  logic [7:0]  tx_byte3;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] acc_q[$];
  logic [2:0] req_hist = '0;

  always #5 clk = ~clk;

  uart_cmd_executor #(.RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_addr(rx_addr),
    .rx_mem_type(rx_mem_type), .rx_rw_flag(rx_rw_flag), .mem_req(mem_req), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .err_overrun(err_overrun)
  );

  uart_cmd_executor #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data), .rx_addr(rx_addr),
    .rx_mem_type(rx_mem_type), .rx_rw_flag(rx_rw_flag), .mem_req(mem_req3), .mem_we(mem_we3),
    .mem_sel(mem_sel3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .tx_byte(tx_byte3), .tx_valid(tx_valid3), .tx_ready(tx_ready), .busy(busy3),
    .err_overrun(err_overrun3)
  );

  // Memory model for the slow instance: read data is valid only 3 cycles after mem_req
  always @(posedge clk) req_hist <= {req_hist[1:0], mem_req3};
  assign mem_rdata3 = req_hist[2] ? 32'hA1B2C3D4 : 32'h5EADBEEF;

  typedef struct {
    logic        rx_done, rw, mt;
    logic [8:0]  addr;
    logic [31:0] data;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req, e_we, e_sel;
    logic [8:0]  e_addr;
    logic [31:0] e_wdata;
    logic        e_valid;
    logic [7:0]  e_byte;
    logic        e_busy;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_cmd(input logic rw, input logic mt, input logic [8:0] a, input logic [31:0] d);
    rx_done = 1'b1; rx_rw_flag = rw; rx_mem_type = mt; rx_addr = a; rx_data = d;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Runs the response phase with a tx_ready pattern; records accepted bytes and mem_req count
  task automatic drain(input logic [7:0] pat, input int npat, input bit ovr, output int reqs);
    int k; bit hold; bit injected; bit finished; logic [7:0] held;
    k = 0; hold = 1'b0; injected = 1'b0; finished = 1'b0; reqs = 0; held = '0;
    acc_q.delete();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      rx_done = 1'b0;
      if (!busy) begin
        finished = 1'b1;
        check("end_tx_valid", tx_valid, 1'b0);
        break;
      end
      if (mem_req) reqs++;
      if (hold) check("hold_tx_byte", tx_byte, held);
      if (tx_valid) begin
        tx_ready = (k < npat) ? pat[k] : 1'b1;
        k++;
        if (tx_ready) acc_q.push_back(tx_byte);
        hold = !tx_ready;
        held = tx_byte;
      end else begin
        tx_ready = 1'b0;
        hold = 1'b0;
      end
      if (ovr && !injected && acc_q.size() == 1) begin
        rx_done = 1'b1; rx_rw_flag = RW_WRITE; rx_mem_type = MEM_DATA;
        rx_addr = 9'h0AA; rx_data = 32'h0;
        injected = 1'b1;
      end
    end
    check("drain_timeout", 32'(finished), 32'd1);
  endtask

  initial begin
    int reqs, n, first_lat;
    logic [7:0] q3[$];
    logic [7:0] exp_rd[4];
    exp_rd[0] = 8'h12; exp_rd[1] = 8'h34; exp_rd[2] = 8'h56; exp_rd[3] = 8'h78;

    //            in: done rw   mt   addr     data          rdy  rdata         | req  we   sel  addr     wdata         valid byte   busy
    vecs[0]  = '{1'b1,1'b1,1'b1,9'h012,32'hDEADBEEF,1'b1,G,            1'b0,1'b0,1'b1,9'h012,32'hDEADBEEF,1'b0,8'h00,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b1,1'b1,1'b1,9'h012,32'hDEADBEEF,1'b0,8'h00,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b1,9'h012,32'hDEADBEEF,1'b1,8'hA5,1'b1};
    vecs[3]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b1,9'h012,32'hDEADBEEF,1'b0,8'h00,1'b0};
    vecs[4]  = '{1'b1,1'b0,1'b0,9'h1FF,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b0,8'h00,1'b1};
    vecs[5]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b1,1'b0,1'b0,9'h1FF,32'h0,       1'b0,8'h00,1'b1};
    vecs[6]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b0,8'h00,1'b1};
    vecs[7]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,32'h12345678, 1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b1,8'h12,1'b1};
    vecs[8]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b1,8'h34,1'b1};
    vecs[9]  = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b1,8'h56,1'b1};
    vecs[10] = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b1,8'h78,1'b1};
    vecs[11] = '{1'b0,1'b0,1'b0,9'h000,32'h0,       1'b1,G,            1'b0,1'b0,1'b0,9'h1FF,32'h0,       1'b0,8'h00,1'b0};

    reset = 1'b1; rx_done = 1'b0; rx_data = '0; rx_addr = '0; rx_mem_type = 1'b0;
    rx_rw_flag = 1'b0; tx_ready = 1'b0; mem_rdata = G;
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_sel", mem_sel, 1'b0);
    check("rst_mem_addr", mem_addr, 9'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_tx_byte", tx_byte, 8'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_overrun, 1'b0);
    reset = 1'b0;

    // Cycle-exact write then read, RD_LATENCY=1
    for (int i = 0; i < 12; i++) begin
      rx_done = vecs[i].rx_done; rx_rw_flag = vecs[i].rw; rx_mem_type = vecs[i].mt;
      rx_addr = vecs[i].addr; rx_data = vecs[i].data; tx_ready = vecs[i].rdy;
      mem_rdata = vecs[i].rdata;
      @(negedge clk);
      check($sformatf("v%0d.mem_req", i), mem_req, vecs[i].e_req);
      check($sformatf("v%0d.mem_we", i), mem_we, vecs[i].e_we);
      check($sformatf("v%0d.mem_sel", i), mem_sel, vecs[i].e_sel);
      check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d.tx_valid", i), tx_valid, vecs[i].e_valid);
      check($sformatf("v%0d.tx_byte", i), tx_byte, vecs[i].e_byte);
      check($sformatf("v%0d.busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d.err", i), err_overrun, 1'b0);
    end
    rx_done = 1'b0;

    // Backpressure: ready pattern 0,0,1,0,1,1,0,1 (bit 0 first)
    mem_rdata = 32'h12345678;
    send_cmd(RW_READ, MEM_INSTR, 9'h1FF, 32'h0);
    drain(8'hB4, 8, 1'b0, reqs);
    check("bp_reqs", reqs, 1);
    check("bp_count", acc_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size()) check($sformatf("bp_byte%0d", i), acc_q[i], exp_rd[i]);
    check("bp_err", err_overrun, 1'b0);

    // Overrun: a write packet arrives during SEND
    send_cmd(RW_READ, MEM_INSTR, 9'h1FF, 32'h0BAD0BAD);
    drain(8'hFF, 8, 1'b1, reqs);
    check("ovr_reqs", reqs, 1);
    check("ovr_count", acc_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < acc_q.size()) check($sformatf("ovr_byte%0d", i), acc_q[i], exp_rd[i]);
    check("ovr_addr", mem_addr, 9'h1FF);
    check("ovr_sel", mem_sel, MEM_INSTR);
    check("ovr_wdata", mem_wdata, 32'h0BAD0BAD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ovr_idle_req%0d", i), mem_req, 1'b0);
      check($sformatf("ovr_idle_busy%0d", i), busy, 1'b0);
      check($sformatf("ovr_sticky%0d", i), err_overrun, 1'b1);
    end

    // Reset after two bytes of a read response have been accepted
    tx_ready = 1'b1;
    send_cmd(RW_READ, MEM_INSTR, 9'h1FF, 32'h0);
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 2; cyc++) begin
      @(negedge clk);
      if (tx_valid && tx_ready) n++;
    end
    check("rst_seq_accepts", n, 2);
    @(negedge clk);
    check("rst_seq_third_byte", tx_byte, 8'h56);
    reset = 1'b1;
    @(negedge clk);
    check("rst_seq_tx_valid", tx_valid, 1'b0);
    check("rst_seq_busy", busy, 1'b0);
    check("rst_seq_err", err_overrun, 1'b0);
    check("rst_seq_req", mem_req, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    send_cmd(RW_WRITE, MEM_DATA, 9'h055, 32'h01020304);
    drain(8'hFF, 8, 1'b0, reqs);
    check("post_rst_reqs", reqs, 1);
    check("post_rst_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("post_rst_ack", acc_q[0], 8'hA5);
    check("post_rst_addr", mem_addr, 9'h055);
    check("post_rst_wdata", mem_wdata, 32'h01020304);
    check("post_rst_sel", mem_sel, MEM_DATA);

    // RD_LATENCY=3 instance: only the word valid 3 cycles after mem_req may be sent
    tx_ready = 1'b1;
    @(negedge clk);
    send_cmd(RW_READ, MEM_DATA, 9'h100, 32'h0);
    first_lat = -1; reqs = 0; n = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (!busy3) begin
        n = 1;
        break;
      end
      if (mem_req3) begin
        reqs++;
        check("l3_req_latency", cyc + 2, 2);
        check("l3_req_we", mem_we3, 1'b0);
      end
      if (tx_valid3 && first_lat < 0) first_lat = cyc + 2;
      if (tx_valid3 && tx_ready) q3.push_back(tx_byte3);
    end
    check("l3_done", n, 1);
    check("l3_reqs", reqs, 1);
    check("l3_first_valid", first_lat, 6);
    check("l3_count", q3.size(), 4);
    exp_rd[0] = 8'hA1; exp_rd[1] = 8'hB2; exp_rd[2] = 8'hC3; exp_rd[3] = 8'hD4;
    for (int i = 0; i < 4; i++)
      if (i < q3.size()) check($sformatf("l3_byte%0d", i), q3[i], exp_rd[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_cmd_executor.md
Name: uart_cmd_executor

Overview:
- Sits directly downstream of the UART multi-byte receiver.
- Consumes each completed command packet: header fields (rw flag, memory type, 9-bit address) plus the 32-bit payload.
- Performs the write or read on the instruction/data memory port.
- Returns a response to the host through a byte-wide UART transmit handshake: one ack byte for a write, four data bytes (MSB first) for a read.
- While a command is in flight, asserts busy so the CPU core can be held off the memories.

Parameters:
- BYTE_COUNT, 4, number of response bytes returned for a read; also the payload width / 8.
- ADDR_WIDTH, 9, width of the memory word address.
- RD_LATENCY, 1, cycles from mem_req (read) to valid mem_rdata; legal range 1..7.
- ACK_BYTE, 8'hA5, byte transmitted after a completed write.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_done  in  1  one-cycle pulse: packet fields below are valid this cycle
- rx_data  in  32  payload word, byte 0 received = bits [31:24]
- rx_addr  in  ADDR_WIDTH  target word address
- rx_mem_type  in  1  0 = instruction memory, 1 = data memory
- rx_rw_flag  in  1  1 = write, 0 = read
- mem_req  out  1  one-cycle memory access strobe
- mem_we  out  1  write enable, qualified by mem_req
- mem_sel  out  1  latched rx_mem_type
- mem_addr  out  ADDR_WIDTH  latched rx_addr
- mem_wdata  out  32  latched rx_data
- mem_rdata  in  32  read data, valid RD_LATENCY cycles after a read mem_req
- tx_byte  out  8  byte to transmit
- tx_valid  out  1  tx_byte is valid
- tx_ready  in  1  transmitter can accept a byte this cycle
- busy  out  1  high in every state except IDLE
- err_overrun  out  1  sticky: an rx_done arrived while not in IDLE

Behaviour:
- Reset (synchronous, sampled on the clk rising edge):
  - state goes to IDLE.
  - All outputs go to 0: mem_req, mem_we, mem_sel, mem_addr, mem_wdata, tx_byte, tx_valid, busy, err_overrun.
  - Internal counters clear and the response shift register clears.
  - Reset wins over every simultaneous event. Asserting it mid-operation aborts the operation with no further mem_req or tx_valid.
- IDLE:
  - When rx_done=1, latch addr, mem_type, rw_flag and data into mem_addr, mem_sel, an internal rw register and mem_wdata.
  - Next state is WRITE when rw=1, otherwise READ.
  - busy rises on the cycle after rx_done.
- WRITE (one cycle): mem_req=1, mem_we=1. Next state is ACK.
- READ:
  - First cycle: mem_req=1, mem_we=0, and the latency counter loads with RD_LATENCY.
  - The counter decrements each cycle.
  - When it reaches 0, capture mem_rdata into a 32-bit shift register, set the byte counter to BYTE_COUNT, and go to SEND.
  - mem_req is high for exactly one cycle per command.
- ACK: tx_byte=ACK_BYTE, tx_valid=1.
  - On the first cycle with tx_valid and tx_ready both high, the byte is accepted; drop tx_valid and go to IDLE.
- SEND: tx_byte = shift register [31:24], tx_valid=1.
  - On acceptance (tx_valid and tx_ready both high), shift left by 8 and decrement the byte counter.
  - The next byte is presented on the following cycle with tx_valid still high. Back-to-back acceptance allows one byte per cycle.
  - After the BYTE_COUNT-th acceptance, drop tx_valid and go to IDLE.
- tx_valid rules:
  - Once raised, tx_valid and tx_byte hold stable until accepted.
  - tx_valid never depends combinationally on tx_ready.
- rx_done outside IDLE:
  - The packet is ignored, the latched command is not modified, and err_overrun is set.
  - err_overrun is cleared only by reset.
- rx_done in the same cycle the FSM returns to IDLE is still not IDLE: ignored, and err_overrun is set.
- Latency:
  - Write: rx_done to mem_req is 2 cycles; rx_done to first tx_valid is 3 cycles.
  - Read: rx_done to mem_req is 2 cycles; first tx_valid appears 3+RD_LATENCY cycles after rx_done.
- Arithmetic and widths: counters are 3 bits, wrap is impossible by construction, and there is no sign extension anywhere.

Decomposition:
- Shared package holds:
  - State encoding localparams: IDLE=0, WRITE=1, READ=2, ACK=3, SEND=4.
  - Memory-type constants: MEM_INSTR=0, MEM_DATA=1.
  - ACK_BYTE default.
  - The rw flag encoding.
- One natural sub-module, tx_byte_serializer: a 32-bit shift register plus byte counter with the valid/ready handshake, also usable by other response paths.
- Everything else stays in one FSM module.

Test Plan:
- Write: rx_done with rw=1, mem_type=1, addr=9'h012, data=32'hDEADBEEF, tx_ready=1.
  - Expect mem_req=mem_we=1, mem_sel=1, mem_addr=012, mem_wdata=DEADBEEF 2 cycles later.
  - Then a single tx_byte=A5, then busy=0.
- Read: rx_done with rw=0, mem_type=0, addr=9'h1FF, mem_rdata=32'h12345678 (RD_LATENCY=1), tx_ready=1.
  - Expect one read mem_req with mem_we=0.
  - Then tx bytes 12, 34, 56, 78 on consecutive cycles.
- Backpressure: same read with tx_ready toggling 0,0,1,0,1,1,0,1.
  - tx_byte holds while tx_ready=0.
  - Exactly four bytes are accepted, in order, with no duplicates.
- Overrun: a second rx_done (write, data 32'h0) during SEND of a read.
  - err_overrun=1 and stays 1.
  - The read response is unchanged and no second mem_req is issued.
- Reset mid-SEND: assert reset after 2 bytes are accepted.
  - The next cycle shows tx_valid=0, busy=0 and err_overrun=0.
  - A following write command completes normally with an A5 ack.
- RD_LATENCY=3 build: mem_rdata is valid only 3 cycles after mem_req (garbage otherwise).
  - The transmitted bytes match the word valid at that cycle.
